aes_sbox_sched: RTL and testbench

- Shared S-box scheduler for the AES core.
- Arbitrates between two requesters: req0 (round datapath, SubBytes columns) and req1 (key expansion, SubWord).
- Each accepted 32-bit word is substituted byte by byte through SBOX_PER_CYCLE instances of the combinational sbox, then returned to the requester that submitted it.
- Sits between the round controller / key schedule and the sbox instances, so the sbox area is not duplicated per consumer.

---
 rtl/aes_sbox_sched_if.sv | 30 +++
 rtl/aes_sbox_sched.sv | 124 ++++++++++++
 tb/tb_aes_sbox_sched.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_sbox_sched_if.sv
// Valid/ready bundle between the two S-box consumers (round datapath, key expansion)
// and the shared scheduler.
interface aes_sbox_sched_if;
  logic        req0_valid;
  logic [31:0] req0_word;
  logic        req0_ready;
  logic        resp0_valid;
  logic [31:0] resp0_word;
  logic        resp0_ready;
  logic        req1_valid;
  logic [31:0] req1_word;
  logic        req1_ready;
  logic        resp1_valid;
  logic [31:0] resp1_word;
  logic        resp1_ready;

  modport master (
    output req0_valid, req0_word, resp0_ready,
    output req1_valid, req1_word, resp1_ready,
    input  req0_ready, resp0_valid, resp0_word,
    input  req1_ready, resp1_valid, resp1_word
  );

  modport slave (
    input  req0_valid, req0_word, resp0_ready,
    input  req1_valid, req1_word, resp1_ready,
    output req0_ready, resp0_valid, resp0_word,
    output req1_ready, resp1_valid, resp1_word
  );
endinterface

// File: rtl/aes_sbox_sched.sv
// Round-robin scheduler sharing SBOX_PER_CYCLE S-box instances between the AES round
// datapath (requester 0) and the key expansion (requester 1), one 32-bit word at a time.
module aes_sbox_sched #(
  parameter int SBOX_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  aes_sbox_sched_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY     = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [1:0] CNT_STEP = 2'(SBOX_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - SBOX_PER_CYCLE);

  generate
    if (SBOX_PER_CYCLE != 1 && SBOX_PER_CYCLE != 2 && SBOX_PER_CYCLE != 4) begin : g_bad_param
      $error("aes_sbox_sched: SBOX_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  logic [1:0]  state;
  logic [1:0]  byte_cnt;
  logic [31:0] data_reg;
  logic [31:0] data_next;
  logic [1:0]  lane;
  logic        owner;
  logic        last_grant;
  logic        grant;
  logic        accept;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Inverse as b^254 in GF(2^8) (which also maps 0 to 0), followed by the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (i != 0) inv = gf_mul(inv, b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else                                  grant = bus.req1_valid;
  end

  assign accept         = !rst && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;

  always_comb begin
    data_next = data_reg;
    lane      = 2'd0;
    for (int k = 0; k < SBOX_PER_CYCLE; k++) begin
      lane = byte_cnt + 2'(k);
      data_next[lane*8 +: 8] = sbox(data_reg[lane*8 +: 8]);
    end
  end

  // The response registers are loaded together with the final byte group so that
  // resp_valid is up in the first DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      byte_cnt        <= 2'd0;
      data_reg        <= '0;
      owner           <= 1'b0;
      last_grant      <= 1'b1;
      bus.resp0_valid <= 1'b0;
      bus.resp0_word  <= '0;
      bus.resp1_valid <= 1'b0;
      bus.resp1_word  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_reg   <= grant ? bus.req1_word : bus.req0_word;
            owner      <= grant;
            last_grant <= grant;
            byte_cnt   <= 2'd0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          data_reg <= data_next;
          byte_cnt <= byte_cnt + CNT_STEP;
          if (byte_cnt == CNT_LAST) begin
            state           <= DONE;
            bus.resp0_valid <= !owner;
            bus.resp0_word  <= owner ? '0 : data_next;
            bus.resp1_valid <= owner;
            bus.resp1_word  <= owner ? data_next : '0;
          end
        end
        DONE: begin
          if (owner ? bus.resp1_ready : bus.resp0_ready) begin
            state           <= IDLE;
            bus.resp0_valid <= 1'b0;
            bus.resp0_word  <= '0;
            bus.resp1_valid <= 1'b0;
            bus.resp1_word  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Directed bench for aes_sbox_sched: one DUT per legal SBOX_PER_CYCLE, selected through
// a small mux so the same stimulus tasks drive whichever instance is under test.
module tb_aes_sbox_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int          sel;
  logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
  logic [31:0] req0_word, req1_word;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [31:0] resp0_word, resp1_word;

  int num_checks = 0;
  int num_fails  = 0;

  typedef struct {
    int          sel;
    bit          which;
    logic [31:0] word;
    logic [31:0] exp_word;
    int          exp_lat;
  } vec_t;

  logic [7:0] sbox_rom [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  aes_sbox_sched_if bus_n1 ();
  aes_sbox_sched_if bus_n2 ();
  aes_sbox_sched_if bus_n4 ();

  aes_sbox_sched #(.SBOX_PER_CYCLE(1)) u_n1 (.clk(clk), .rst(rst), .bus(bus_n1));
  aes_sbox_sched #(.SBOX_PER_CYCLE(2)) u_n2 (.clk(clk), .rst(rst), .bus(bus_n2));
  aes_sbox_sched #(.SBOX_PER_CYCLE(4)) u_n4 (.clk(clk), .rst(rst), .bus(bus_n4));

  assign bus_n1.req0_valid  = (sel == 0) && req0_valid;
  assign bus_n1.req1_valid  = (sel == 0) && req1_valid;
  assign bus_n1.resp0_ready = (sel == 0) && resp0_ready;
  assign bus_n1.resp1_ready = (sel == 0) && resp1_ready;
  assign bus_n1.req0_word   = req0_word;
  assign bus_n1.req1_word   = req1_word;
  assign bus_n2.req0_valid  = (sel == 1) && req0_valid;
  assign bus_n2.req1_valid  = (sel == 1) && req1_valid;
  assign bus_n2.resp0_ready = (sel == 1) && resp0_ready;
  assign bus_n2.resp1_ready = (sel == 1) && resp1_ready;
  assign bus_n2.req0_word   = req0_word;
  assign bus_n2.req1_word   = req1_word;
  assign bus_n4.req0_valid  = (sel == 2) && req0_valid;
  assign bus_n4.req1_valid  = (sel == 2) && req1_valid;
  assign bus_n4.resp0_ready = (sel == 2) && resp0_ready;
  assign bus_n4.resp1_ready = (sel == 2) && resp1_ready;
  assign bus_n4.req0_word   = req0_word;
  assign bus_n4.req1_word   = req1_word;

  always_comb begin
    case (sel)
      1: begin
        req0_ready = bus_n2.req0_ready; resp0_valid = bus_n2.resp0_valid; resp0_word = bus_n2.resp0_word;
        req1_ready = bus_n2.req1_ready; resp1_valid = bus_n2.resp1_valid; resp1_word = bus_n2.resp1_word;
      end
      2: begin
        req0_ready = bus_n4.req0_ready; resp0_valid = bus_n4.resp0_valid; resp0_word = bus_n4.resp0_word;
        req1_ready = bus_n4.req1_ready; resp1_valid = bus_n4.resp1_valid; resp1_word = bus_n4.resp1_word;
      end
      default: begin
        req0_ready = bus_n1.req0_ready; resp0_valid = bus_n1.resp0_valid; resp0_word = bus_n1.resp0_word;
        req1_ready = bus_n1.req1_ready; resp1_valid = bus_n1.resp1_valid; resp1_word = bus_n1.resp1_word;
      end
    endcase
  end

  function automatic logic [31:0] model_word(input logic [31:0] w);
    return {sbox_rom[w[31:24]], sbox_rom[w[23:16]], sbox_rom[w[15:8]], sbox_rom[w[7:0]]};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name);
    num_checks++;
    num_fails++;
    $display("[TB] FAIL %s: got no handshake within 50 cycles, expected one", name);
  endtask

  // Returns at negedge+1 with the chosen ready high; the following posedge accepts.
  task automatic wait_ready(input bit which, input string name, output bit ok);
    int waited;
    waited = 0;
    #1;
    while (!(which ? req1_ready : req0_ready) && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    ok = (waited < 50);
    if (!ok) report_timeout(name);
  endtask

  task automatic wait_resp(input bit which, input string name, output bit ok);
    int waited;
    waited = 0;
    while (!(which ? resp1_valid : resp0_valid) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    ok = (waited < 50);
    if (!ok) report_timeout(name);
  endtask

  // One full transaction; lat counts edges from the accept edge up to the resp_valid edge inclusive.
  task automatic apply_stimulus(input bit which, input logic [31:0] word,
                                output logic [31:0] got, output int lat, output bit other_seen);
    bit ok;
    got = '0;
    lat = 0;
    other_seen = 1'b0;
    if (which) begin req1_valid = 1'b1; req1_word = word; end
    else       begin req0_valid = 1'b1; req0_word = word; end
    wait_ready(which, "accept", ok);
    if (!ok) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    while (!(which ? resp1_valid : resp0_valid) && lat < 50) begin
      if (which ? resp0_valid : resp1_valid) other_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) begin
      report_timeout("response");
      return;
    end
    if (which ? resp0_valid : resp1_valid) other_seen = 1'b1;
    got = which ? resp1_word : resp0_word;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [7];
    bit          exp_order [3];
    logic [31:0] got;
    logic [31:0] word;
    int          lat;
    bit          other;
    bit          ok;
    int          waited;
    bit          winner;

    vecs[0] = '{0, 1'b0, 32'h5301_00FF, 32'hED7C_6316, 5};
    vecs[1] = '{1, 1'b0, 32'h5301_00FF, 32'hED7C_6316, 3};
    vecs[2] = '{2, 1'b0, 32'h5301_00FF, 32'hED7C_6316, 2};
    vecs[3] = '{0, 1'b1, 32'h108F_C700, 32'hCA73_C663, 5};
    vecs[4] = '{1, 1'b1, 32'h0102_0304, 32'h7C77_7BF2, 3};
    vecs[5] = '{2, 1'b1, 32'hFFFF_FFFF, 32'h1616_1616, 2};
    vecs[6] = '{1, 1'b0, 32'h0000_0000, 32'h6363_6363, 3};
    exp_order = '{1'b0, 1'b1, 1'b0};

    // Reset with both requesters already valid: nothing may be accepted while rst is high.
    sel = 0;
    rst = 1'b1;
    req0_valid = 1'b1; req0_word = 32'h0000_0000;
    req1_valid = 1'b1; req1_word = 32'hFFFF_FFFF;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    @(negedge clk);
    check_bit("reset req0_ready", req0_ready, 1'b0);
    check_bit("reset req1_ready", req1_ready, 1'b0);
    check_bit("reset resp0_valid", resp0_valid, 1'b0);
    check_bit("reset resp1_valid", resp1_valid, 1'b0);
    check_output("reset resp0_word", resp0_word, 32'h0);
    check_output("reset resp1_word", resp1_word, 32'h0);
    check_bit("reset n2 resp0_valid", bus_n2.resp0_valid, 1'b0);
    check_bit("reset n4 resp1_valid", bus_n4.resp1_valid, 1'b0);
    rst = 1'b0;

    for (int g = 0; g < 3; g++) begin
      waited = 0;
      #1;
      while (!(req0_ready || req1_ready) && waited < 50) begin
        @(negedge clk);
        #1;
        waited++;
      end
      if (waited >= 50) begin
        report_timeout("tie grant");
        break;
      end
      check_bit("tie single ready", req0_ready && req1_ready, 1'b0);
      check_bit("tie grant order", req1_ready, exp_order[g]);
      winner = req1_ready;
      @(negedge clk);
      waited = 0;
      while (!(resp0_valid || resp1_valid) && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      check_bit("tie resp owner", resp1_valid, winner);
      check_output("tie resp word", winner ? resp1_word : resp0_word,
                   winner ? 32'h1616_1616 : 32'h6363_6363);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Table: single requests on every instance, checking word, latency and the idle response.
    foreach (vecs[i]) begin
      @(negedge clk);
      sel = vecs[i].sel;
      apply_stimulus(vecs[i].which, vecs[i].word, got, lat, other);
      check_output("vector word", got, vecs[i].exp_word);
      check_output("vector latency", 32'(lat), 32'(vecs[i].exp_lat));
      check_bit("vector other resp idle", other, 1'b0);
    end

    // Backpressure on requester 1 while requester 0 waits.
    @(negedge clk);
    sel = 0;
    resp1_ready = 1'b0;
    req1_valid = 1'b1; req1_word = 32'h5301_00FF;
    wait_ready(1'b1, "bp accept", ok);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_word = 32'h0000_0000;
    wait_resp(1'b1, "bp resp1", ok);
    for (int i = 0; i < 10; i++) begin
      check_bit("bp resp1_valid held", resp1_valid, 1'b1);
      check_output("bp resp1_word held", resp1_word, 32'hED7C_6316);
      check_bit("bp req0 blocked", req0_ready, 1'b0);
      @(negedge clk);
    end
    resp1_ready = 1'b1;
    @(negedge clk);
    check_bit("bp resp1 released", resp1_valid, 1'b0);
    check_bit("bp req0 granted next", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_resp(1'b0, "bp resp0", ok);
    check_output("bp resp0_word", resp0_word, 32'h6363_6363);

    // Requester 1 arrives while requester 0 is being processed.
    @(negedge clk);
    req0_valid = 1'b1; req0_word = 32'h0101_0101;
    wait_ready(1'b0, "busy accept", ok);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_word = 32'h1010_1010;
    waited = 0;
    while (!resp0_valid && waited < 50) begin
      #1;
      check_bit("busy req1 held off", req1_ready, 1'b0);
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) report_timeout("busy resp0");
    check_output("busy resp0_word", resp0_word, 32'h7C7C_7C7C);
    req0_valid = 1'b1;
    #1;
    check_bit("busy req1 held in done", req1_ready, 1'b0);
    @(negedge clk);
    #1;
    check_bit("busy req1 granted", req1_ready, 1'b1);
    check_bit("busy req0 not granted", req0_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_resp(1'b1, "busy resp1", ok);
    check_output("busy resp1_word", resp1_word, 32'hCACA_CACA);

    // Asynchronous reset with byte_cnt at 2 on the N=1 instance.
    @(negedge clk);
    req0_valid = 1'b1; req0_word = 32'hAABB_CCDD;
    wait_ready(1'b0, "abort accept", ok);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_word = 32'hFFFF_FFFF;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_bit("abort req1_ready", req1_ready, 1'b0);
    check_bit("abort resp0_valid", resp0_valid, 1'b0);
    check_bit("abort resp1_valid", resp1_valid, 1'b0);
    check_output("abort resp0_word", resp0_word, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req1_valid = 1'b0;
    waited = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp0_valid || resp1_valid) waited++;
      @(negedge clk);
    end
    check_output("abort no response", 32'(waited), 32'h0);
    req0_valid = 1'b1; req0_word = 32'h5301_00FF;
    req1_valid = 1'b1;
    #1;
    check_bit("abort last_grant req0", req0_ready, 1'b1);
    check_bit("abort last_grant req1", req1_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_resp(1'b0, "abort resp0", ok);
    check_output("abort resp0 after", resp0_word, 32'hED7C_6316);
    wait_ready(1'b1, "abort req1 accept", ok);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_resp(1'b1, "abort resp1", ok);
    check_output("abort resp1 after", resp1_word, 32'h1616_1616);

    // Every byte value through every lane, on the N=1 and N=4 instances.
    for (int s = 0; s < 3; s += 2) begin
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        sel = s;
        word = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
        apply_stimulus((i % 2) == 1, word, got, lat, other);
        check_output("sbox lane word", got, model_word(word));
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
